// File: rtl/ascon_p_inv.sv
// ascon_p_inv: iterative inverse of the Ascon-p permutation, one inverse round per clock.
// Latency: done is high nr cycles after the load edge (2*nr with ASCON_P_INV_LDREG_EN).
// Backpressure: start is ignored while busy=1; results stay on s_out until the next accepted start.
// ASCON_P_INV_LDREG_EN: registers the L-inverse output, so each round takes two cycles.
module ascon_p_inv #(
  parameter int BW = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [3:0]      nr,
  input  logic [5*BW-1:0] s_in,
  output logic [5*BW-1:0] s_out,
  output logic            busy,
  output logic            done,
  output logic [3:0]      r
);

`ifdef ASCON_P_INV_LDREG_EN
  typedef enum logic [1:0] {IDLE, RUN, LDREG} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t          state;
  logic [3:0]      cnt;
  logic [3:0]      nr_clamp;
  logic [5*BW-1:0] lin_out;
  logic [5*BW-1:0] sbox_in;
  logic [5*BW-1:0] rc_mask;
  logic [5*BW-1:0] s_next;

  // Rotate right; amount is already reduced mod 64 by the caller.
  function automatic logic [BW-1:0] rotr(input logic [BW-1:0] x, input int unsigned n);
    logic [2*BW-1:0] d;
    d = {x, x} >> n;
    return d[BW-1:0];
  endfunction

  // (I + R^a + R^b)^63 built as six squaring stages: rotations double each stage.
  function automatic logic [BW-1:0] linv_word(input logic [BW-1:0] x,
                                              input int unsigned a,
                                              input int unsigned b);
    logic [BW-1:0] y;
    y = x;
    for (int k = 0; k < 6; k++) begin
      y = y ^ rotr(y, (a << k) % 64) ^ rotr(y, (b << k) % 64);
    end
    return y;
  endfunction

  function automatic logic [5*BW-1:0] linv(input logic [5*BW-1:0] s);
    return {linv_word(s[5*BW-1:4*BW], 19, 28),
            linv_word(s[4*BW-1:3*BW], 61, 39),
            linv_word(s[3*BW-1:2*BW],  1,  6),
            linv_word(s[2*BW-1:1*BW], 10, 17),
            linv_word(s[1*BW-1:0],     7, 41)};
  endfunction

  // Inverse of the 5-bit Ascon S-box; column index is {x0,x1,x2,x3,x4}, x0 as MSB.
  function automatic logic [4:0] sinv5(input logic [4:0] v);
    logic [4:0] o;
    case (v)
      5'd0:  o = 5'd20;  5'd1:  o = 5'd26;  5'd2:  o = 5'd7;   5'd3:  o = 5'd13;
      5'd4:  o = 5'd0;   5'd5:  o = 5'd9;   5'd6:  o = 5'd14;  5'd7:  o = 5'd18;
      5'd8:  o = 5'd10;  5'd9:  o = 5'd6;   5'd10: o = 5'd29;  5'd11: o = 5'd1;
      5'd12: o = 5'd25;  5'd13: o = 5'd21;  5'd14: o = 5'd19;  5'd15: o = 5'd30;
      5'd16: o = 5'd24;  5'd17: o = 5'd22;  5'd18: o = 5'd11;  5'd19: o = 5'd17;
      5'd20: o = 5'd3;   5'd21: o = 5'd5;   5'd22: o = 5'd28;  5'd23: o = 5'd31;
      5'd24: o = 5'd23;  5'd25: o = 5'd27;  5'd26: o = 5'd4;   5'd27: o = 5'd8;
      5'd28: o = 5'd15;  5'd29: o = 5'd12;  5'd30: o = 5'd16;  default: o = 5'd2;
    endcase
    return o;
  endfunction

  // Bitsliced S-box inverse: one table lookup per bit column across the five words.
  function automatic logic [5*BW-1:0] sinv(input logic [5*BW-1:0] s);
    logic [5*BW-1:0] y;
    logic [4:0]      v;
    y = '0;
    for (int j = 0; j < BW; j++) begin
      v = sinv5({s[4*BW+j], s[3*BW+j], s[2*BW+j], s[BW+j], s[j]});
      y[4*BW+j] = v[4];
      y[3*BW+j] = v[3];
      y[2*BW+j] = v[2];
      y[BW+j]   = v[1];
      y[j]      = v[0];
    end
    return y;
  endfunction

  assign nr_clamp = (nr > 4'd12) ? 4'd12 : nr;
  assign lin_out  = linv(s_out);

  // Round constant for index r lands in the low byte of word 2: {0xF - r, r}.
  always_comb begin
    rc_mask = '0;
    rc_mask[2*BW +: 8] = {4'hF - r, r};
  end

`ifdef ASCON_P_INV_LDREG_EN
  logic [5*BW-1:0] l_reg;
  assign sbox_in = l_reg;
`else
  assign sbox_in = lin_out;
`endif

  assign s_next = sinv(sbox_in) ^ rc_mask;

  // Control FSM and state register: load on start, one inverse round per RUN (or LDREG) edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      s_out <= '0;
      cnt   <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ASCON_P_INV_LDREG_EN
      l_reg <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s_out <= s_in;
            cnt   <= nr_clamp;
            r     <= 4'd11;
            if (nr_clamp == 4'd0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
`ifdef ASCON_P_INV_LDREG_EN
        RUN: begin
          l_reg <= lin_out;
          state <= LDREG;
        end
        LDREG: begin
          s_out <= s_next;
          cnt   <= cnt - 4'd1;
          r     <= r - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
`else
        RUN: begin
          s_out <= s_next;
          cnt   <= cnt - 4'd1;
          r     <= r - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_p_inv.sv
// tb_ascon_p_inv: scoreboard bench for ascon_p_inv using an independent forward Ascon-p model.
// Each accepted start pushes the expected result; each done pulse pops and checks it.
// Covers reset state, round trips, nr=0/clamp, ignored starts, back-to-back and mid-run reset.
module tb_ascon_p_inv;

`ifdef ASCON_P_INV_LDREG_EN
  localparam int MUL = 2;
`else
  localparam int MUL = 1;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   nr = 4'd0;
  logic [319:0] s_in = '0;
  logic [319:0] s_out;
  logic         busy;
  logic         done;
  logic [3:0]   r;

  typedef struct {
    logic [319:0] din;
    logic [319:0] exp;
    logic         has_exp;
    int           nrc;
    int           load_cyc;
  } sb_t;

  sb_t sbq[$];
  int  n_chk = 0;
  int  n_bad = 0;
  int  cyc = 0;

  ascon_p_inv #(.BW(64)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .nr    (nr),
    .s_in  (s_in),
    .s_out (s_out),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Forward Ascon round: constant, S-box, linear layer.
  function automatic logic [319:0] fround(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    {x0, x1, x2, x3, x4} = s;
    c  = 8'(240 - 16 * i + i);
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] fwd(input logic [319:0] s, input int n);
    logic [319:0] t;
    t = s;
    for (int i = 12 - n; i < 12; i++) t = fround(t, i);
    return t;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start (caller is at posedge+1 with busy low) and record its expectation.
  task automatic launch(input logic [319:0] si, input logic [3:0] n,
                        input logic [319:0] ex, input logic hx);
    sb_t e;
    e.din      = si;
    e.exp      = ex;
    e.has_exp  = hx;
    e.nrc      = (n > 4'd12) ? 12 : int'(n);
    e.load_cyc = cyc + 1;
    sbq.push_back(e);
    start = 1'b1;
    s_in  = si;
    nr    = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) chk("done_timeout", 320'(done), 320'(1));
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    sb_t e;
    if (rstn && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 320'(done), 320'(0));
      end else begin
        e = sbq.pop_front();
        chk("latency", 320'(cyc - e.load_cyc), 320'(e.nrc * MUL));
        chk("busy_at_done", 320'(busy), 320'(0));
        chk("r_after", 320'(r), 320'((11 - e.nrc) & 15));
        chk("fwd_of_out", fwd(s_out, e.nrc), e.din);
        if (e.has_exp) chk("s_out", s_out, e.exp);
      end
    end
  end

  initial begin
    logic [319:0] x, x6;
    logic [3:0]   n;
    int           nc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_out", s_out, 320'(0));
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_done", 320'(done), 320'(0));
    chk("rst_r", 320'(r), 320'(0));
    #3 rstn = 1'b1;
    tick();

    // 12-round round trip from the all-zero state
    launch(fwd('0, 12), 4'd12, '0, 1'b1);
    chk("busy_after_load", 320'(busy), 320'(1));
    wait_done();

    // 6-round round trip on a fixed pattern
    x6 = 320'h0123456789ABCDEF_FEDCBA9876543210_00112233445566778899AABBCCDDEEFF_0F1E2D3C4B5A6978;
    launch(fwd(x6, 6), 4'd6, x6, 1'b1);
    wait_done();

    // nr=0 passes the state straight through
    x = rnd320();
    launch(x, 4'd0, x, 1'b1);
    wait_done();

    // nr=15 clamps to 12 on zero input, then an explicit nr=12 on the same input
    launch('0, 4'd15, '0, 1'b0);
    wait_done();
    launch('0, 4'd12, '0, 1'b0);
    wait_done();

    // starts during busy must be ignored
    x = rnd320();
    launch(fwd(x, 12), 4'd12, x, 1'b1);
    tick(); tick();
    start = 1'b1; s_in = rnd320(); nr = 4'd3;
    tick();
    start = 1'b0;
    chk("busy_mid_run", 320'(busy), 320'(1));
    tick(); tick(); tick();
    start = 1'b1; s_in = rnd320(); nr = 4'd1;
    tick();
    start = 1'b0;
    wait_done();

    // back-to-back: new start in the done cycle
    x = rnd320();
    launch(fwd(x, 4), 4'd4, x, 1'b1);
    wait_done();
    x = rnd320();
    launch(fwd(x, 5), 4'd5, x, 1'b1);
    wait_done();

    // random round counts including clamped values
    for (int t = 0; t < 6; t++) begin
      x  = rnd320();
      n  = 4'($urandom_range(0, 15));
      nc = (n > 4'd12) ? 12 : int'(n);
      launch(fwd(x, nc), n, x, 1'b1);
      wait_done();
    end

    // asynchronous reset in the middle of a run
    x = rnd320();
    launch(fwd(x, 12), 4'd12, x, 1'b1);
    repeat (4) tick();
    #1 rstn = 1'b0;
    #1;
    chk("abort_s_out", s_out, 320'(0));
    chk("abort_busy", 320'(busy), 320'(0));
    chk("abort_done", 320'(done), 320'(0));
    chk("abort_r", 320'(r), 320'(0));
    void'(sbq.pop_back());
    #3 rstn = 1'b1;
    repeat (30) tick();
    chk("idle_after_abort", 320'(busy), 320'(0));
    x = rnd320();
    launch(fwd(x, 12), 4'd12, x, 1'b1);
    wait_done();

    tick(); tick();
    chk("sb_empty", 320'(sbq.size()), 320'(0));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
